// File: rtl/flag_hazard_ctrl.sv
// V/Z/N condition-flag pipeline controller: tracks flag writers, commits them, and resolves branches.
// Build macro FLAG_CTRL_FWD_EN: forward MEM-stage flags to branch resolution (stall on EX writers only).
module flag_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [2:0] ex_flag_mask,
  input  logic       ex_ovfl,
  input  logic       ex_zero,
  input  logic       ex_sign,
  input  logic       ex_flush,
  input  logic       pipe_stall,
  input  logic       id_br,
  input  logic [2:0] id_cond,
  output logic       flag_en,
  output logic       ovfl_wr,
  output logic       zero_wr,
  output logic       sign_wr,
  output logic       byp_ovfl,
  output logic       byp_zero,
  output logic       byp_sign,
  output logic       flag_stall,
  output logic       br_valid,
  output logic       br_taken
);

  typedef enum logic [2:0] {
    CondNe     = 3'b000,
    CondEq     = 3'b001,
    CondGt     = 3'b010,
    CondLt     = 3'b011,
    CondGte    = 3'b100,
    CondLte    = 3'b101,
    CondOvfl   = 3'b110,
    CondUncond = 3'b111
  } cond_e;

  // Flag vectors are packed {V,Z,N}: bit 2 = V, bit 1 = Z, bit 0 = N.
  logic       r_memValid;
  logic [2:0] r_memMask;
  logic [2:0] r_memFlags;
  logic       r_wbValid;
  logic [2:0] r_wbMask;
  logic [2:0] r_wbFlags;
  logic [2:0] r_shadow;

  logic [2:0] w_exFlags;
  logic       w_exEntry;
  logic [2:0] w_exHit;
  logic [2:0] w_memHit;
  logic [2:0] w_wbHit;
  logic [2:0] w_wrData;
  logic [2:0] w_hazard;
  logic [2:0] w_resolved;
  logic [2:0] w_needed;
  logic       w_taken;
  logic       w_stall;

  assign w_exFlags = {ex_ovfl, ex_zero, ex_sign};
  assign w_exEntry = ex_valid & ~ex_flush & (|ex_flag_mask);
  assign w_exHit   = (ex_valid & ~ex_flush) ? ex_flag_mask : 3'b000;
  assign w_memHit  = r_memValid ? r_memMask : 3'b000;
  assign w_wbHit   = r_wbValid ? r_wbMask : 3'b000;

  // Unwritten flags take the shadow copy so the single write strobe never corrupts them.
  assign w_wrData  = (w_wbHit & r_wbFlags) | (~w_wbHit & r_shadow);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_memValid <= 1'b0;
      r_memMask  <= 3'b000;
      r_memFlags <= 3'b000;
      r_wbValid  <= 1'b0;
      r_wbMask   <= 3'b000;
      r_wbFlags  <= 3'b000;
      r_shadow   <= 3'b000;
    end else if (!pipe_stall) begin
      r_memValid <= w_exEntry;
      r_memMask  <= ex_flag_mask;
      r_memFlags <= w_exFlags;
      r_wbValid  <= r_memValid;
      r_wbMask   <= r_memMask;
      r_wbFlags  <= r_memFlags;
      if (r_wbValid) begin
        r_shadow <= w_wrData;
      end
    end
  end

`ifdef FLAG_CTRL_FWD_EN
  assign w_hazard   = w_exHit;
  assign w_resolved = (w_memHit & r_memFlags) | (~w_memHit & w_wrData);
`else
  assign w_hazard   = w_exHit | w_memHit;
  assign w_resolved = w_wrData;
`endif

  always_comb begin
    w_needed = 3'b000;
    w_taken  = 1'b0;
    case (cond_e'(id_cond))
      CondNe: begin
        w_needed = 3'b010;
        w_taken  = ~w_resolved[1];
      end
      CondEq: begin
        w_needed = 3'b010;
        w_taken  = w_resolved[1];
      end
      CondGt: begin
        w_needed = 3'b011;
        w_taken  = ~w_resolved[1] & ~w_resolved[0];
      end
      CondLt: begin
        w_needed = 3'b001;
        w_taken  = w_resolved[0];
      end
      CondGte: begin
        w_needed = 3'b011;
        w_taken  = w_resolved[1] | ~w_resolved[0];
      end
      CondLte: begin
        w_needed = 3'b011;
        w_taken  = w_resolved[1] | w_resolved[0];
      end
      CondOvfl: begin
        w_needed = 3'b100;
        w_taken  = w_resolved[2];
      end
      CondUncond: begin
        w_needed = 3'b000;
        w_taken  = 1'b1;
      end
      default: begin
        w_needed = 3'b000;
        w_taken  = 1'b0;
      end
    endcase
  end

  assign w_stall = id_br & (|(w_needed & w_hazard));

  // Every output is forced low while reset is asserted.
  assign flag_en    = ~rst & r_wbValid & ~pipe_stall;
  assign ovfl_wr    = ~rst & w_wrData[2];
  assign zero_wr    = ~rst & w_wrData[1];
  assign sign_wr    = ~rst & w_wrData[0];
  assign byp_ovfl   = ~rst & w_wbHit[2];
  assign byp_zero   = ~rst & w_wbHit[1];
  assign byp_sign   = ~rst & w_wbHit[0];
  assign flag_stall = ~rst & w_stall;
  assign br_valid   = ~rst & id_br & ~w_stall & ~pipe_stall;
  assign br_taken   = ~rst & id_br & w_taken;

endmodule
